// File: rtl/vc_dest_arbiter.sv
// Weighted round-robin pop scheduler between two VC FIFOs, routing each returned
// word to one of two destination FIFOs with a one-word stall buffer.
module vc_dest_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_BIT   = 4,
  parameter int WEIGHT_VC0 = 2,
  parameter int WEIGHT_VC1 = 1,
  parameter int CRED_W     = 3
) (
  input  logic                  clk,
  input  logic                  RESET_L,
  input  logic                  enable,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic                  vc0_valid,
  input  logic                  vc1_valid,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  input  logic                  d0_pause,
  input  logic                  d1_pause,
  input  logic                  d0_full,
  input  logic                  d1_full,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic [DATA_WIDTH-1:0] data_to_d0,
  output logic [DATA_WIDTH-1:0] data_to_d1,
  output logic                  last_grant,
  output logic                  busy,
  output logic                  protocol_err
);

  typedef enum logic [1:0] {IDLE, WAIT, STALL} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_prio, w_prio_nxt;
  logic [CRED_W-1:0]     r_credit, w_credit_nxt;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_dest;

  logic                  w_can_pop, w_gnt, w_pop, w_latch, w_err;
  logic                  w_push0, w_push1, w_stray;
  logic                  w_in_valid, w_in_dest, w_in_full, w_hold_full;
  logic [DATA_WIDTH-1:0] w_in_data, w_push_data;

  function automatic logic [CRED_W-1:0] wt(input logic vc);
    return vc ? CRED_W'(WEIGHT_VC1) : CRED_W'(WEIGHT_VC0);
  endfunction

  // Destination is unknown until the word returns, so either pause blocks every pop.
  assign w_can_pop   = enable & ~d0_pause & ~d1_pause & ~(vc0_empty & vc1_empty);
  assign w_gnt       = r_prio ? ~vc1_empty : vc0_empty;

  assign w_in_valid  = last_grant ? vc1_valid : vc0_valid;
  assign w_in_data   = last_grant ? vc1_data  : vc0_data;
  assign w_in_dest   = w_in_data[DEST_BIT];
  assign w_in_full   = w_in_dest ? d1_full : d0_full;
  assign w_hold_full = r_hold_dest ? d1_full : d0_full;

  // Only the VC popped in the previous cycle may present valid.
  assign w_stray = (r_state == WAIT) ? (last_grant ? vc0_valid : vc1_valid)
                                     : (vc0_valid | vc1_valid);

  always_comb begin
    w_prio_nxt   = r_prio;
    w_credit_nxt = r_credit;
    if (w_gnt == r_prio) begin
      if (r_credit <= CRED_W'(1)) begin
        w_prio_nxt   = ~r_prio;
        w_credit_nxt = wt(~r_prio);
      end else begin
        w_credit_nxt = r_credit - CRED_W'(1);
      end
    end else if (wt(w_gnt) <= CRED_W'(1)) begin
      w_prio_nxt   = ~w_gnt;
      w_credit_nxt = wt(~w_gnt);
    end else begin
      w_prio_nxt   = w_gnt;
      w_credit_nxt = wt(w_gnt) - CRED_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_push0     = 1'b0;
    w_push1     = 1'b0;
    w_push_data = w_in_data;
    w_latch     = 1'b0;
    w_err       = w_stray;
    case (r_state)
      IDLE: begin
        if (w_can_pop) begin
          w_pop       = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!w_in_valid) begin
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_in_full) begin
          w_latch     = 1'b1;
          w_state_nxt = STALL;
        end else begin
          w_push0 = ~w_in_dest;
          w_push1 = w_in_dest;
          if (w_can_pop) w_pop = 1'b1;
          else           w_state_nxt = IDLE;
        end
      end
      STALL: begin
        if (!w_hold_full) begin
          w_push0     = ~r_hold_dest;
          w_push1     = r_hold_dest;
          w_push_data = r_hold_data;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign pop_vc0 = RESET_L & w_pop & ~w_gnt;
  assign pop_vc1 = RESET_L & w_pop & w_gnt;
  assign busy    = (r_state != IDLE);

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state      <= IDLE;
      r_prio       <= 1'b0;
      r_credit     <= CRED_W'(WEIGHT_VC0);
      r_hold_data  <= '0;
      r_hold_dest  <= 1'b0;
      push_d0      <= 1'b0;
      push_d1      <= 1'b0;
      data_to_d0   <= '0;
      data_to_d1   <= '0;
      last_grant   <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_prio     <= w_prio_nxt;
        r_credit   <= w_credit_nxt;
        last_grant <= w_gnt;
      end
      if (w_latch) begin
        r_hold_data <= w_in_data;
        r_hold_dest <= w_in_dest;
      end
      push_d0 <= w_push0;
      push_d1 <= w_push1;
      if (w_push0) data_to_d0 <= w_push_data;
      if (w_push1) data_to_d1 <= w_push_data;
      if (w_err)   protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Bench for vc_dest_arbiter: VC FIFOs modelled as queues, WRR grant model and
// an in-order word scoreboard.
module tb_vc_dest_arbiter;
  localparam int DW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic RESET_L, enable, vc0_empty, vc1_empty, vc0_valid, vc1_valid;
  logic [DW-1:0] vc0_data, vc1_data;
  logic d0_pause, d1_pause, d0_full, d1_full;
  logic pop_vc0, pop_vc1, push_d0, push_d1, last_grant, busy, protocol_err;
  logic [DW-1:0] data_to_d0, data_to_d1;

  vc_dest_arbiter #(.DATA_WIDTH(DW), .DEST_BIT(4), .WEIGHT_VC0(2), .WEIGHT_VC1(1), .CRED_W(3)) dut (
    .clk(clk), .RESET_L(RESET_L), .enable(enable),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_valid(vc0_valid), .vc1_valid(vc1_valid),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .d0_pause(d0_pause), .d1_pause(d1_pause),
    .d0_full(d0_full), .d1_full(d1_full),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .push_d0(push_d0), .push_d1(push_d1),
    .data_to_d0(data_to_d0), .data_to_d1(data_to_d1),
    .last_grant(last_grant), .busy(busy), .protocol_err(protocol_err)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q0[$], q1[$], exp_q[$];
  logic pend0, pend1;
  logic [DW-1:0] pw0, pw1;
  logic n_en, n_p0, n_p1, n_f0, n_f1, n_withhold, n_spur1;
  logic s_pop0, s_pop1, s_push0, s_push1, s_busy, s_err, s_lg;
  logic [DW-1:0] s_d0, s_d1;

  // WRR model: a turn belongs to one VC and lasts its weight in grants; a grant
  // to the other VC starts that VC's turn.
  int owner, used;

  function automatic int wt(int vc);
    return (vc != 0) ? 1 : 2;
  endfunction

  function automatic int wrr_pick(logic e0, logic e1);
    if (owner == 0) return e0 ? 1 : 0;
    return e1 ? 0 : 1;
  endfunction

  task automatic wrr_take(int vc);
    if (vc != owner) begin owner = vc; used = 0; end
    used++;
    if (used == wt(owner)) begin owner = 1 - owner; used = 0; end
  endtask

  task automatic apply_reset();
    RESET_L = 1'b0;
    enable = 0; vc0_empty = 1; vc1_empty = 1; vc0_valid = 0; vc1_valid = 0;
    vc0_data = '0; vc1_data = '0; d0_pause = 0; d1_pause = 0; d0_full = 0; d1_full = 0;
    n_en = 0; n_p0 = 0; n_p1 = 0; n_f0 = 0; n_f1 = 0; n_withhold = 0; n_spur1 = 0;
    pend0 = 0; pend1 = 0; pw0 = '0; pw1 = '0;
    q0.delete(); q1.delete(); exp_q.delete();
    owner = 0; used = 0;
    repeat (2) @(posedge clk);
    #1 RESET_L = 1'b1;
  endtask

  // One clock: apply inputs just after the edge, sample mid-cycle, then let the
  // VC FIFO model answer any pop with valid data in the next cycle.
  task automatic step();
    @(posedge clk); #1;
    enable = n_en; d0_pause = n_p0; d1_pause = n_p1; d0_full = n_f0; d1_full = n_f1;
    vc0_valid = pend0 & ~n_withhold; vc0_data = pw0;
    vc1_valid = pend1 | n_spur1;     vc1_data = pw1;
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
    #4;
    s_pop0 = pop_vc0; s_pop1 = pop_vc1; s_push0 = push_d0; s_push1 = push_d1;
    s_d0 = data_to_d0; s_d1 = data_to_d1; s_busy = busy; s_err = protocol_err; s_lg = last_grant;
    pend0 = 0; pend1 = 0;
    if (s_pop0 && q0.size() > 0) begin pw0 = q0.pop_front(); pend0 = 1; exp_q.push_back(pw0); end
    if (s_pop1 && q1.size() > 0) begin pw1 = q1.pop_front(); pend1 = 1; exp_q.push_back(pw1); end
  endtask

  task automatic test_reset();
    RESET_L = 1'b0;
    enable = 1; vc0_empty = 0; vc1_empty = 0; d0_pause = 0; d1_pause = 0;
    #1;
    checks++; if ({pop_vc0, pop_vc1} !== 2'b00) begin errors++; $display("FAIL reset_pop got=%b exp=00", {pop_vc0, pop_vc1}); end
    checks++; if ({push_d0, push_d1} !== 2'b00) begin errors++; $display("FAIL reset_push got=%b exp=00", {push_d0, push_d1}); end
    checks++; if ({data_to_d0, data_to_d1} !== 12'h000) begin errors++; $display("FAIL reset_data got=%h exp=000", {data_to_d0, data_to_d1}); end
    checks++; if ({last_grant, busy, protocol_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {last_grant, busy, protocol_err}); end
    apply_reset();
    step();
    checks++; if ({s_busy, s_pop0, s_pop1} !== 3'b000) begin errors++; $display("FAIL reset_idle got=%b exp=000", {s_busy, s_pop0, s_pop1}); end
  endtask

  task automatic test_wrr_fill();
    int pat[6] = '{0, 0, 1, 0, 0, 1};
    logic [DW-1:0] w;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      q0.push_back(DW'($urandom_range(0, 63)));
      q1.push_back(DW'($urandom_range(0, 63)));
    end
    n_en = 1;
    for (int k = 0; k < 9; k++) begin
      step();
      if (k < 6) begin
        checks++;
        if ((s_pop0 ^ s_pop1) !== 1'b1 || int'(s_pop1) != pat[k]) begin
          errors++; $display("FAIL wrr_seq[%0d] got pop0=%b pop1=%b exp vc%0d", k, s_pop0, s_pop1, pat[k]);
        end
      end
      checks++;
      if (k < 2) begin
        if ((s_push0 | s_push1) !== 1'b0) begin errors++; $display("FAIL wrr_fill[%0d] got push=%b%b exp=00", k, s_push1, s_push0); end
      end else if (exp_q.size() == 0) begin
        errors++; $display("FAIL wrr_push[%0d] got no popped word exp push", k);
      end else begin
        w = exp_q.pop_front();
        if (w[4] ? (s_push1 !== 1'b1 || s_push0 !== 1'b0 || s_d1 !== w)
                 : (s_push0 !== 1'b1 || s_push1 !== 1'b0 || s_d0 !== w)) begin
          errors++; $display("FAIL wrr_push[%0d] got p0=%b p1=%b d0=%h d1=%h exp word=%h", k, s_push0, s_push1, s_d0, s_d1, w);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    apply_reset();
    q1.push_back(6'h30); q1.push_back(6'h31); q1.push_back(6'h32);
    n_en = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (s_pop0 !== 1'b0 || s_pop1 !== (k < 3)) begin
        errors++; $display("FAIL b2b_pop[%0d] got pop0=%b pop1=%b exp pop1=%0d", k, s_pop0, s_pop1, (k < 3));
      end
      e = DW'(6'h30 + k - 2);
      checks++;
      if (s_push0 !== 1'b0 || s_push1 !== (k >= 2 && k < 5) || ((k >= 2 && k < 5) && s_d1 !== e)) begin
        errors++; $display("FAIL b2b_push[%0d] got p0=%b p1=%b d1=%h exp d1=%h", k, s_push0, s_push1, s_d1, e);
      end
    end
  endtask

  task automatic test_full_stall();
    apply_reset();
    q0.push_back(6'h05); q1.push_back(6'h3A);
    n_en = 1; n_f0 = 1;
    step();
    checks++; if ({s_pop0, s_pop1} !== 2'b10) begin errors++; $display("FAIL stall_pop got=%b%b exp=10", s_pop0, s_pop1); end
    for (int k = 1; k < 4; k++) begin
      step();
      checks++;
      if ({s_pop0, s_pop1, s_push0, s_push1} !== 4'b0000 || (k > 1 && s_busy !== 1'b1)) begin
        errors++; $display("FAIL stall_hold[%0d] got pops=%b%b push=%b%b busy=%b exp none busy=1", k, s_pop0, s_pop1, s_push0, s_push1, s_busy);
      end
    end
    n_f0 = 0;
    step();
    checks++; if ({s_push0, s_busy} !== 2'b01) begin errors++; $display("FAIL stall_release got push0=%b busy=%b exp 0,1", s_push0, s_busy); end
    step();
    checks++; if (s_push0 !== 1'b1 || s_d0 !== 6'h05) begin errors++; $display("FAIL stall_push got push0=%b d0=%h exp 1,05", s_push0, s_d0); end
    checks++; if (s_busy !== 1'b0 || s_pop1 !== 1'b1) begin errors++; $display("FAIL stall_idle got busy=%b pop1=%b exp 0,1", s_busy, s_pop1); end
  endtask

  task automatic test_pause();
    apply_reset();
    for (int i = 0; i < 10; i++) begin q0.push_back(DW'(i)); q1.push_back(DW'(6'h10 + i)); end
    n_en = 1;
    step(); step();
    checks++; if ({s_pop0, s_pop1} !== 2'b10) begin errors++; $display("FAIL pause_pre got=%b%b exp=10", s_pop0, s_pop1); end
    n_p1 = 1;
    for (int k = 2; k < 6; k++) begin
      step();
      checks++;
      if ({s_pop0, s_pop1} !== 2'b00 || (s_push0 | s_push1) !== (k < 4)) begin
        errors++; $display("FAIL pause_hold[%0d] got pops=%b%b push=%b%b exp no pop push=%0d", k, s_pop0, s_pop1, s_push0, s_push1, (k < 4));
      end
    end
    n_p1 = 0;
    step();
    checks++; if ({s_pop0, s_pop1} !== 2'b01) begin errors++; $display("FAIL pause_resume got=%b%b exp=01", s_pop0, s_pop1); end
    step();
    checks++; if ({s_pop0, s_pop1} !== 2'b10) begin errors++; $display("FAIL pause_next got=%b%b exp=10", s_pop0, s_pop1); end
  endtask

  task automatic test_protocol_err();
    apply_reset();
    q0.push_back(6'h07);
    n_en = 1; n_withhold = 1;
    step();
    checks++; if (s_pop0 !== 1'b1) begin errors++; $display("FAIL perr_pop got=%b exp=1", s_pop0); end
    n_en = 0;
    step();
    n_withhold = 0;
    for (int k = 2; k < 5; k++) begin
      step();
      checks++;
      if (s_err !== 1'b1 || s_busy !== 1'b0 || (s_push0 | s_push1) !== 1'b0) begin
        errors++; $display("FAIL perr_sticky[%0d] got err=%b busy=%b push=%b%b exp 1,0,00", k, s_err, s_busy, s_push0, s_push1);
      end
    end
    apply_reset();
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL perr_clear got=%b exp=0", protocol_err); end
    n_spur1 = 1;
    step();
    n_spur1 = 0;
    step();
    checks++; if (s_err !== 1'b1 || (s_push0 | s_push1) !== 1'b0) begin errors++; $display("FAIL perr_stray got err=%b push=%b%b exp 1,00", s_err, s_push0, s_push1); end
  endtask

  task automatic test_reset_in_stall();
    apply_reset();
    q1.push_back(6'h1F);
    n_en = 1;
    step();
    checks++; if ({s_pop0, s_pop1} !== 2'b01) begin errors++; $display("FAIL rst_stall_pop1 got=%b%b exp=01", s_pop0, s_pop1); end
    step();
    q0.push_back(6'h05); n_f0 = 1;
    step();
    checks++; if (s_push1 !== 1'b1 || s_d1 !== 6'h1F || s_pop0 !== 1'b1) begin errors++; $display("FAIL rst_stall_pre got p1=%b d1=%h pop0=%b exp 1,1f,1", s_push1, s_d1, s_pop0); end
    step(); step();
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL rst_stall_busy got=%b exp=1", s_busy); end
    RESET_L = 1'b0;
    #1;
    checks++; if ({busy, push_d0, push_d1} !== 3'b000) begin errors++; $display("FAIL rst_async_flags got=%b exp=000", {busy, push_d0, push_d1}); end
    checks++; if ({data_to_d0, data_to_d1} !== 12'h000) begin errors++; $display("FAIL rst_async_data got=%h exp=000", {data_to_d0, data_to_d1}); end
    apply_reset();
    for (int i = 0; i < 6; i++) begin q0.push_back(DW'(i)); q1.push_back(DW'(6'h18 + i)); end
    n_en = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({s_pop0, s_pop1} !== ((k == 2) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rst_regrant[%0d] got=%b%b exp vc%0d", k, s_pop0, s_pop1, (k == 2));
      end
    end
  endtask

  task automatic test_random();
    logic pf0, pf1, legal;
    logic [DW-1:0] w;
    int g;
    apply_reset();
    n_en = 1;
    for (int k = 0; k < 440; k++) begin
      if (k < 400) begin
        n_en = ($urandom_range(0, 7) != 0);
        n_p0 = ($urandom_range(0, 9) == 0);
        n_p1 = ($urandom_range(0, 9) == 0);
        n_f0 = ($urandom_range(0, 3) == 0);
        n_f1 = ($urandom_range(0, 3) == 0);
        if (q0.size() < 3 && $urandom_range(0, 1) == 1) q0.push_back(DW'($urandom_range(0, 63)));
        if (q1.size() < 3 && $urandom_range(0, 2) == 0) q1.push_back(DW'($urandom_range(0, 63)));
      end else begin
        n_en = 1; n_p0 = 0; n_p1 = 0; n_f0 = 0; n_f1 = 0;
      end
      pf0 = d0_full; pf1 = d1_full;
      step();
      checks++; if (s_pop0 && s_pop1) begin errors++; $display("FAIL rnd_pop_excl[%0d] got=11 exp one hot", k); end
      if (s_pop0 | s_pop1) begin
        legal = enable & ~d0_pause & ~d1_pause & (s_pop0 ? ~vc0_empty : ~vc1_empty);
        checks++; if (!legal) begin errors++; $display("FAIL rnd_pop_legal[%0d] got pop=%b%b en=%b pause=%b%b empty=%b%b", k, s_pop0, s_pop1, enable, d0_pause, d1_pause, vc0_empty, vc1_empty); end
        g = wrr_pick(vc0_empty, vc1_empty);
        checks++; if (int'(s_pop1) != g) begin errors++; $display("FAIL rnd_grant[%0d] got vc%0d exp vc%0d", k, s_pop1, g); end
        wrr_take(g);
      end
      checks++; if (s_push0 && s_push1) begin errors++; $display("FAIL rnd_push_excl[%0d] got=11 exp one hot", k); end
      if (s_push0 | s_push1) begin
        checks++; if (s_push0 ? pf0 : pf1) begin errors++; $display("FAIL rnd_push_full[%0d] got push=%b%b full_prev=%b%b", k, s_push0, s_push1, pf0, pf1); end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_push_extra[%0d] got push with no word outstanding", k);
        end else begin
          w = exp_q.pop_front();
          if (w[4] ? (s_push1 !== 1'b1 || s_d1 !== w) : (s_push0 !== 1'b1 || s_d0 !== w)) begin
            errors++; $display("FAIL rnd_push_word[%0d] got p0=%b p1=%b d0=%h d1=%h exp word=%h", k, s_push0, s_push1, s_d0, s_d1, w);
          end
        end
      end
    end
    checks++; if (exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) begin errors++; $display("FAIL rnd_drain got left=%0d q0=%0d q1=%0d exp 0", exp_q.size(), q0.size(), q1.size()); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL rnd_perr got=%b exp=0", protocol_err); end
  endtask

  initial begin
    RESET_L = 1'b1;
    enable = 0; vc0_empty = 1; vc1_empty = 1; vc0_valid = 0; vc1_valid = 0;
    vc0_data = '0; vc1_data = '0; d0_pause = 0; d1_pause = 0; d0_full = 0; d1_full = 0;
    #2;
    test_reset();
    test_wrr_fill();
    test_back_to_back();
    test_full_stall();
    test_pause();
    test_protocol_err();
    test_reset_in_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
